// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC execute pipeline: opcode and branch-condition
// encodings, default datapath widths, and flag-update classification helpers.
package wisc_pkg;

    localparam int W_DEF  = 16;
    localparam int DW_DEF = 4;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_PADDSB = 4'h1,
        OP_SUB    = 4'h2,
        OP_AND    = 4'h3,
        OP_NOR    = 4'h4,
        OP_SLL    = 4'h5,
        OP_SRL    = 4'h6,
        OP_SRA    = 4'h7
    } op_e;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_UN = 3'b111
    } cond_e;

    // Arithmetic ops own the full Z/V/N set; logic and shift ops only touch Z.
    function automatic logic opSetsAll(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic opSetsZ(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_NOR) || (op == OP_SLL) || (op == OP_SRL) ||
               (op == OP_SRA);
    endfunction

endpackage

// File: rtl/ex_flag_stage_br_cond_eval.sv
// Purely combinational branch-condition evaluator over the Z/V/N flags.
module br_cond_eval
    import wisc_pkg::*;
(
    input  logic       z,
    input  logic       v,
    input  logic       n,
    input  logic [2:0] cond,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            CC_NE:   take = ~z;
            CC_EQ:   take = z;
            CC_GT:   take = ~z & ~n;
            CC_LT:   take = n;
            CC_GE:   take = z | ~n;
            CC_LE:   take = n | z;
            CC_OV:   take = v;
            CC_UN:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// Execute-stage output register: holds the arithmetic result behind a
// ready/valid handshake, maintains the Z/V/N flag register and resolves branches.
module ex_flag_stage
    import wisc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_result,
    input  logic          in_v,
    input  logic          in_n,
    input  logic [3:0]    in_op,
    input  logic [DW-1:0] in_dst,
    input  logic          in_wr,
    input  logic          br_valid,
    input  logic [2:0]    br_cond,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [DW-1:0] out_dst,
    output logic          out_wr,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          br_taken
);

    logic          r_out_valid;
    logic [W-1:0]  r_result;
    logic [DW-1:0] r_dst;
    logic          r_wr;
    logic          r_z, r_v, r_n;
    logic          r_br_taken;

    logic w_accept;
    logic w_upd_all;
    logic w_upd_z;
    logic w_z_new;
    logic w_eff_z, w_eff_v, w_eff_n;
    logic w_take;

    assign in_ready  = ~r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_upd_all = w_accept & opSetsAll(in_op);
    assign w_upd_z   = w_accept & opSetsZ(in_op);
    assign w_z_new   = (in_result == '0);

    // Branches see same-cycle flag updates so a compare can feed a branch back-to-back.
    assign w_eff_z = w_upd_z   ? w_z_new : r_z;
    assign w_eff_v = w_upd_all ? in_v    : r_v;
    assign w_eff_n = w_upd_all ? in_n    : r_n;

    br_cond_eval u_br_cond_eval (
        .z    (w_eff_z),
        .v    (w_eff_v),
        .n    (w_eff_n),
        .cond (br_cond),
        .take (w_take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_dst       <= '0;
            r_wr        <= 1'b0;
        end else begin
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_accept)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;
            if (w_accept) begin
                r_result <= in_result;
                r_dst    <= in_dst;
                r_wr     <= in_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z        <= 1'b0;
            r_v        <= 1'b0;
            r_n        <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_z        <= w_eff_z;
            r_v        <= w_eff_v;
            r_n        <= w_eff_n;
            r_br_taken <= br_valid & w_take & ~flush;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_dst    = r_dst;
    assign out_wr     = r_wr;
    assign flag_z     = r_z;
    assign flag_v     = r_v;
    assign flag_n     = r_n;
    assign br_taken   = r_br_taken;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed table-driven bench for ex_flag_stage with hand-computed expectations,
// plus hand-written reset sequences.
module tb_ex_flag_stage;
    import wisc_pkg::*;

    typedef struct {
        logic        inValid;
        logic [15:0] inResult;
        logic        inV;
        logic        inN;
        logic [3:0]  inOp;
        logic [3:0]  inDst;
        logic        inWr;
        logic        brValid;
        logic [2:0]  brCond;
        logic        flush;
        logic        outReady;
        logic        expInReady;
        logic        expOutValid;
        logic [15:0] expResult;
        logic [3:0]  expDst;
        logic        expWr;
        logic [2:0]  expFlags;
        logic        expBr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_result;
    logic        in_v, in_n;
    logic [3:0]  in_op;
    logic [3:0]  in_dst;
    logic        in_wr;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic        out_wr;
    logic        flag_z, flag_v, flag_n;
    logic        br_taken;

    int nVectors = 0;
    int nCompares = 0;
    int nMiss = 0;
    vec_t vecs[21];

    ex_flag_stage #(.W(16), .DW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_v(in_v), .in_n(in_n),
        .in_op(in_op), .in_dst(in_dst), .in_wr(in_wr),
        .br_valid(br_valid), .br_cond(br_cond), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dst(out_dst), .out_wr(out_wr),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nCompares++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ov, input logic [15:0] res,
                            input logic [3:0] dst, input logic wr, input logic [2:0] flags,
                            input logic bt);
        checkOutput({tag, ".out_valid"},  {15'd0, out_valid}, {15'd0, ov});
        checkOutput({tag, ".out_result"}, out_result, res);
        checkOutput({tag, ".out_dst"},    {12'd0, out_dst}, {12'd0, dst});
        checkOutput({tag, ".out_wr"},     {15'd0, out_wr}, {15'd0, wr});
        checkOutput({tag, ".flags_zvn"},  {13'd0, flag_z, flag_v, flag_n}, {13'd0, flags});
        checkOutput({tag, ".br_taken"},   {15'd0, br_taken}, {15'd0, bt});
    endtask

    // Inputs change 1ns after a rising edge; outputs are checked 1ns after the next one.
    task automatic applyStimulus(input string tag, input vec_t v);
        in_valid  = v.inValid;
        in_result = v.inResult;
        in_v      = v.inV;
        in_n      = v.inN;
        in_op     = v.inOp;
        in_dst    = v.inDst;
        in_wr     = v.inWr;
        br_valid  = v.brValid;
        br_cond   = v.brCond;
        flush     = v.flush;
        out_ready = v.outReady;
        #1;
        checkOutput({tag, ".in_ready"}, {15'd0, in_ready}, {15'd0, v.expInReady});
        @(posedge clk);
        #1;
        checkAll(tag, v.expOutValid, v.expResult, v.expDst, v.expWr, v.expFlags, v.expBr);
        nVectors++;
    endtask

    initial begin
        //          vld res      v     n     op         dst   wr    bv    cond   fl    ordy | ir    ov    res      dst   wr    zvn     bt
        vecs[0]  = '{1'b1, 16'h0000, 1'b1, 1'b0, OP_ADD,    4'h3, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h3, 1'b1, 3'b110, 1'b0};
        vecs[1]  = '{1'b1, 16'h8001, 1'b0, 1'b1, OP_SUB,    4'h5, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8001, 4'h5, 1'b1, 3'b001, 1'b0};
        vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b1, OP_ADD,    4'h2, 1'b0, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h2, 1'b0, 3'b111, 1'b0};
        vecs[3]  = '{1'b1, 16'h8000, 1'b0, 1'b0, OP_AND,    4'h7, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 4'h7, 1'b1, 3'b011, 1'b0};
        vecs[4]  = '{1'b1, 16'h0000, 1'b1, 1'b0, OP_PADDSB, 4'h1, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h1, 1'b1, 3'b011, 1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, OP_ADD,    4'h0, 1'b0, 1'b1, CC_OV, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h1, 1'b1, 3'b011, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, OP_ADD,    4'h0, 1'b0, 1'b1, CC_EQ, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'h1, 1'b1, 3'b011, 1'b0};
        vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, OP_NOR,    4'h4, 1'b0, 1'b1, CC_EQ, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h4, 1'b0, 3'b111, 1'b1};
        vecs[8]  = '{1'b1, 16'h0010, 1'b0, 1'b0, OP_SRA,    4'h6, 1'b1, 1'b1, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 4'h6, 1'b1, 3'b011, 1'b1};
        vecs[9]  = '{1'b1, 16'h0000, 1'b1, 1'b1, OP_ADD,    4'h2, 1'b1, 1'b1, CC_UN, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 4'h6, 1'b1, 3'b011, 1'b0};
        vecs[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, OP_SLL,    4'h8, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h8, 1'b1, 3'b111, 1'b0};
        vecs[11] = '{1'b1, 16'h1234, 1'b0, 1'b0, OP_SUB,    4'h9, 1'b1, 1'b1, CC_GE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h8, 1'b1, 3'b111, 1'b1};
        vecs[12] = '{1'b1, 16'h1234, 1'b0, 1'b0, OP_SUB,    4'h9, 1'b1, 1'b0, CC_NE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h8, 1'b1, 3'b111, 1'b0};
        vecs[13] = '{1'b1, 16'h1234, 1'b0, 1'b0, OP_SUB,    4'h9, 1'b1, 1'b0, CC_NE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h8, 1'b1, 3'b111, 1'b0};
        vecs[14] = '{1'b1, 16'h1234, 1'b0, 1'b0, OP_SUB,    4'h9, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 4'h9, 1'b1, 3'b000, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, OP_ADD,    4'h0, 1'b0, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 4'h9, 1'b1, 3'b000, 1'b0};
        vecs[16] = '{1'b1, 16'hFFF0, 1'b0, 1'b1, OP_SUB,    4'hA, 1'b1, 1'b1, CC_LT, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFF0, 4'hA, 1'b1, 3'b001, 1'b1};
        vecs[17] = '{1'b1, 16'h0001, 1'b0, 1'b0, OP_ADD,    4'hB, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 4'hB, 1'b1, 3'b000, 1'b0};
        vecs[18] = '{1'b1, 16'hFFF0, 1'b0, 1'b1, OP_SUB,    4'hA, 1'b1, 1'b1, CC_GT, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFF0, 4'hA, 1'b1, 3'b001, 1'b0};
        vecs[19] = '{1'b1, 16'h0000, 1'b1, 1'b1, OP_ADD,    4'hC, 1'b1, 1'b0, CC_NE, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'hC, 1'b1, 3'b111, 1'b0};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, OP_ADD,    4'h0, 1'b0, 1'b0, CC_NE, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'hC, 1'b1, 3'b111, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_result = '0; in_v = 1'b0; in_n = 1'b0;
        in_op = OP_ADD; in_dst = '0; in_wr = 1'b0;
        br_valid = 1'b0; br_cond = CC_NE; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 16'h0000, 4'h0, 1'b0, 3'b000, 1'b0);
        checkOutput("reset.in_ready", {15'd0, in_ready}, 16'd1);
        nVectors++;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Stage is now stalled with a valid payload and flags 111; reset must clear it asynchronously.
        #1;
        rst_n = 1'b0;
        #1;
        checkAll("midReset", 1'b0, 16'h0000, 4'h0, 1'b0, 3'b000, 1'b0);
        checkOutput("midReset.in_ready", {15'd0, in_ready}, 16'd1);
        nVectors++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("postReset", '{1'b1, 16'h0005, 1'b0, 1'b0, OP_ADD, 4'h1, 1'b1, 1'b0, CC_NE, 1'b0, 1'b0,
                                     1'b1, 1'b1, 16'h0005, 4'h1, 1'b1, 3'b000, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
